// File: rtl/task_8_input_if.sv
// Byte-stream bundle between the task manager, the task 8 input block and the task 8 core.
// The slave modport is the input block's view; the master modport is the surrounding environment.
interface task_8_input_if #(
    parameter int DATA_W = 8
);
    logic              tmanager_valid;
    logic [DATA_W-1:0] tdata;
    logic              tmanager_data_last;
    logic [11:0]       packet_size_in_bytes;
    logic              tinput_ready;
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              core_ready;
    logic              busy;
    logic              pkt_done;
    logic              pkt_err;
    logic [11:0]       byte_count;

    modport slave (
        input  tmanager_valid, tdata, tmanager_data_last, packet_size_in_bytes, core_ready,
        output tinput_ready, data, data_valid, busy, pkt_done, pkt_err, byte_count
    );

    modport master (
        output tmanager_valid, tdata, tmanager_data_last, packet_size_in_bytes, core_ready,
        input  tinput_ready, data, data_valid, busy, pkt_done, pkt_err, byte_count
    );
endinterface

// File: rtl/task_8_input.sv
// Task 8 input block: buffers one manager packet, checks its length, then streams it to the core
// or flushes it with an error pulse.
module task_8_input #(
    parameter int          DATA_W            = 8,
    parameter int          FIFO_ADDR_W       = 8,
    parameter logic [11:0] PKT_SIZE_IN_BYTES = 12'd64
) (
    input logic            i_clk,
    input logic            i_rst,
    task_8_input_if.slave  bus
);

    localparam int                   DEPTH   = 1 << FIFO_ADDR_W;
    localparam logic [FIFO_ADDR_W:0] PTR_ONE = {{FIFO_ADDR_W{1'b0}}, 1'b1};
    localparam logic [11:0]          CNT_MAX = 12'd4095;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_CHECK = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FLUSH = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [DATA_W-1:0]    mem_r [DEPTH];
    logic [FIFO_ADDR_W:0] wr_ptr_r;
    logic [FIFO_ADDR_W:0] rd_ptr_r;
    logic [11:0]          count_r;
    logic [11:0]          size_r;
    logic                 overrun_r;
    logic                 ready_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 err_r;

    logic                 beat_s;
    logic                 write_s;
    logic                 empty_s;
    logic                 valid_s;
    logic                 xfer_s;
    logic                 last_xfer_s;
    logic                 pass_s;
    logic                 ready_nxt_s;
    logic                 busy_nxt_s;
    logic                 done_nxt_s;
    logic                 err_nxt_s;

    // Handshake qualifiers and the length verdict used by CHECK.
    always_comb begin
        beat_s      = bus.tmanager_valid & ready_r;
        empty_s     = (wr_ptr_r == rd_ptr_r);
        valid_s     = (state_r == ST_DRAIN) & ~empty_s;
        xfer_s      = valid_s & bus.core_ready;
        last_xfer_s = xfer_s & ((rd_ptr_r + PTR_ONE) == wr_ptr_r);
        pass_s      = (count_r == size_r) & (count_r == PKT_SIZE_IN_BYTES) &
                      ~overrun_r & (size_r != 12'd0);
        if (state_r == ST_IDLE) begin
            write_s = beat_s;
        end else if (state_r == ST_RECV) begin
            write_s = beat_s & (count_r < PKT_SIZE_IN_BYTES);
        end else begin
            write_s = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (beat_s) begin
                    state_s = bus.tmanager_data_last ? ST_CHECK : ST_RECV;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RECV: begin
                if (beat_s && bus.tmanager_data_last) begin
                    state_s = ST_CHECK;
                end else begin
                    state_s = ST_RECV;
                end
            end
            ST_CHECK: begin
                state_s = pass_s ? ST_DRAIN : ST_FLUSH;
            end
            ST_DRAIN: begin
                // An empty FIFO here cannot occur after a passing check; recover to IDLE anyway.
                if (last_xfer_s || empty_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_FLUSH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the registered status outputs.
    always_comb begin
        ready_nxt_s = (state_s == ST_IDLE) | (state_s == ST_RECV);
        busy_nxt_s  = (state_s != ST_IDLE);
        done_nxt_s  = last_xfer_s;
        err_nxt_s   = (state_r == ST_FLUSH);
    end

    // Registered status outputs; all read 0 straight out of reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= ready_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            err_r   <= err_nxt_s;
        end
    end

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge i_clk) begin
        if (write_s) begin
            mem_r[wr_ptr_r[FIFO_ADDR_W-1:0]] <= bus.tdata;
        end
    end

    // FIFO pointers, byte counter, latched size and overrun flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_r  <= {(FIFO_ADDR_W+1){1'b0}};
            rd_ptr_r  <= {(FIFO_ADDR_W+1){1'b0}};
            count_r   <= 12'd0;
            size_r    <= 12'd0;
            overrun_r <= 1'b0;
        end else begin
            if (write_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (xfer_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end else if (state_r == ST_FLUSH) begin
                rd_ptr_r <= wr_ptr_r;
            end

            if (state_s == ST_IDLE) begin
                count_r <= 12'd0;
            end else if (beat_s && (state_r == ST_IDLE)) begin
                count_r <= 12'd1;
            end else if (beat_s && (count_r != CNT_MAX)) begin
                count_r <= count_r + 12'd1;
            end

            if (beat_s && (state_r == ST_IDLE)) begin
                size_r <= bus.packet_size_in_bytes;
            end

            if (state_r == ST_IDLE) begin
                overrun_r <= 1'b0;
            end else if (beat_s && (state_r == ST_RECV) && (count_r >= PKT_SIZE_IN_BYTES)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign bus.tinput_ready = ready_r;
    assign bus.data         = valid_s ? mem_r[rd_ptr_r[FIFO_ADDR_W-1:0]] : {DATA_W{1'b0}};
    assign bus.data_valid   = valid_s;
    assign bus.busy         = busy_r;
    assign bus.pkt_done     = done_r;
    assign bus.pkt_err      = err_r;
    assign bus.byte_count   = count_r;

endmodule

// File: tb/tb_task_8_input.sv
// Self-checking bench for task_8_input: directed scenarios plus random packets scored against
// a packet-level model (a packet passes only when its length equals both the declared and fixed size).
module tb_task_8_input;

    logic clk;
    logic rst;

    task_8_input_if #(.DATA_W(8)) bus ();

    task_8_input #(
        .DATA_W            (8),
        .FIFO_ADDR_W       (8),
        .PKT_SIZE_IN_BYTES (12'd64)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;
    int         err_cnt  = 0;
    int         valid_cycles = 0;
    int         peak_bc  = 0;
    int         cr_mode  = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'd0;
    logic [7:0] got_q [$];
    logic [7:0] sent_q [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check_val("stall_valid", 32'(bus.data_valid), 32'd1);
                check_val("stall_data", 32'(bus.data), 32'(prev_data));
            end
            if (bus.data_valid) valid_cycles++;
            if (bus.data_valid && bus.core_ready) got_q.push_back(bus.data);
            if (bus.pkt_done) done_cnt++;
            if (bus.pkt_err) err_cnt++;
            if (int'(bus.byte_count) > peak_bc) peak_bc = int'(bus.byte_count);
            prev_stall = bus.data_valid && !bus.core_ready;
            prev_data  = bus.data;
        end
    end

    // Core-side ready driver: 0 = always ready, 1 = 1,0,0,1 pattern, 2 = random.
    initial begin
        bit [3:0] pat;
        int       ph;
        pat = 4'b1001;
        ph  = 0;
        bus.core_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (cr_mode)
                0: bus.core_ready = 1'b1;
                1: begin
                    bus.core_ready = pat[ph];
                    ph = (ph + 1) % 4;
                end
                default: bus.core_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_beat(input logic [7:0] b, input logic last, input logic [11:0] decl);
        logic acc;
        int   k;
        bus.tmanager_valid       = 1'b1;
        bus.tdata                = b;
        bus.tmanager_data_last   = last;
        bus.packet_size_in_bytes = decl;
        acc = 1'b0;
        k   = 0;
        while (!acc && k < 1000) begin
            acc = bus.tinput_ready;
            @(posedge clk);
            #1;
            k++;
        end
        if (!acc) check_val("beat_timeout", 32'd0, 32'd1);
        bus.tmanager_valid     = 1'b0;
        bus.tmanager_data_last = 1'b0;
    endtask

    task automatic run_pkt(input int n, input int decl, input bit gap, input bit offer, input bit rnd);
        bit         pass;
        int         d0, e0, v0, k, exp_n;
        logic [7:0] b;
        pass = (n == decl) && (n == 64);
        got_q.delete();
        sent_q.delete();
        peak_bc = 0;
        d0 = done_cnt;
        e0 = err_cnt;
        v0 = valid_cycles;
        for (int i = 0; i < n; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            sent_q.push_back(b);
            if (gap) begin
                bus.tmanager_valid     = 1'b0;
                bus.tmanager_data_last = 1'b1;
                @(posedge clk);
                #1;
                bus.tmanager_data_last = 1'b0;
            end
            send_beat(b, (i == n - 1), 12'(decl));
        end
        check_val("check_ready_low", 32'(bus.tinput_ready), 32'd0);
        check_val("check_busy", 32'(bus.busy), 32'd1);
        @(posedge clk);
        #1;
        check_val("first_valid", 32'(bus.data_valid), 32'(pass));
        if (offer) begin
            bus.tmanager_valid = 1'b1;
            bus.tdata          = 8'hA5;
        end
        k = 0;
        while (!(bus.pkt_done || bus.pkt_err) && k < 1000) begin
            if (offer) check_val("offer_blocked", 32'(bus.tinput_ready), 32'd0);
            @(posedge clk);
            #1;
            k++;
        end
        bus.tmanager_valid = 1'b0;
        if (k >= 1000) check_val("pkt_timeout", 32'd0, 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        exp_n = pass ? n : 0;
        check_val("done_pulses", 32'(done_cnt - d0), 32'(pass));
        check_val("err_pulses", 32'(err_cnt - e0), 32'(!pass));
        check_val("busy_after", 32'(bus.busy), 32'd0);
        check_val("count_after", 32'(bus.byte_count), 32'd0);
        check_val("peak_count", 32'(peak_bc), 32'(n));
        check_val("delivered", 32'(got_q.size()), 32'(exp_n));
        if (!pass) check_val("valid_cycles", 32'(valid_cycles - v0), 32'd0);
        if (pass && got_q.size() == n) begin
            for (int i = 0; i < n; i++) check_val("byte", 32'(got_q[i]), 32'(sent_q[i]));
        end
    endtask

    initial begin
        int n, decl;
        rst = 1'b1;
        bus.tmanager_valid       = 1'b0;
        bus.tdata                = 8'd0;
        bus.tmanager_data_last   = 1'b0;
        bus.packet_size_in_bytes = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_ready", 32'(bus.tinput_ready), 32'd0);
        check_val("reset_valid", 32'(bus.data_valid), 32'd0);
        check_val("reset_busy", 32'(bus.busy), 32'd0);
        check_val("reset_count", 32'(bus.byte_count), 32'd0);
        rst = 1'b0;

        cr_mode = 0;
        run_pkt(64, 64, 1'b0, 1'b0, 1'b0);   // nominal
        run_pkt(10, 10, 1'b0, 1'b0, 1'b1);   // short
        run_pkt(70, 70, 1'b0, 1'b0, 1'b1);   // overrun
        cr_mode = 1;
        run_pkt(64, 64, 1'b0, 1'b1, 1'b1);   // backpressure + offered byte
        cr_mode = 0;

        // Reset in the middle of receiving.
        for (int i = 0; i < 30; i++) send_beat(8'(i + 100), 1'b0, 12'd64);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("midrst_ready", 32'(bus.tinput_ready), 32'd0);
        check_val("midrst_valid", 32'(bus.data_valid), 32'd0);
        check_val("midrst_data", 32'(bus.data), 32'd0);
        check_val("midrst_busy", 32'(bus.busy), 32'd0);
        check_val("midrst_done", 32'(bus.pkt_done), 32'd0);
        check_val("midrst_err", 32'(bus.pkt_err), 32'd0);
        check_val("midrst_count", 32'(bus.byte_count), 32'd0);
        rst = 1'b0;
        run_pkt(64, 64, 1'b0, 1'b0, 1'b1);

        run_pkt(64, 64, 1'b1, 1'b0, 1'b1);   // gapped input with stray last
        run_pkt(64, 0, 1'b0, 1'b0, 1'b1);    // declared size 0

        repeat (6) begin
            n    = ($urandom_range(0, 1) != 0) ? 64 : int'($urandom_range(1, 80));
            decl = ($urandom_range(0, 3) != 0) ? n : int'($urandom_range(0, 100));
            cr_mode = int'($urandom_range(0, 2));
            run_pkt(n, decl, 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
